// File: rtl/wb_dma_copy.sv
// Wishbone word-copy engine: slave port holds SRC/DST/LEN/CTRL, master port
// copies LEN words from SRC to DST, one outstanding bus cycle at a time.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-low reset
//   s_*                   register slave: [3:2] 0 SRC, 1 DST, 2 LEN, 3 CTRL
//   m_*                   copy master: read SRC, write DST, sel always 4'hF
//   irq_o                 DONE & IEN
module wb_dma_copy #(
  parameter int LEN_W = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] s_adr_i,
  input  logic [31:0] s_dat_i,
  output logic [31:0] s_dat_o,
  input  logic [3:0]  s_sel_i,
  input  logic        s_stb_i,
  input  logic        s_cyc_i,
  input  logic        s_we_i,
  output logic        s_ack_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  output logic [3:0]  m_sel_o,
  output logic        m_stb_o,
  output logic        m_cyc_o,
  output logic        m_we_o,
  input  logic        m_ack_i,
  output logic        irq_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WGAP, S_WRITE, S_RGAP
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [31:0]      data_q, data_d;
  logic             ien_q, ien_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             abort_q, abort_d;
  logic             s_ack_q, s_ack_d;
  logic [31:0]      s_dat_q, s_dat_d;
  logic             m_cyc_q, m_cyc_d;
  logic             m_we_q, m_we_d;
  logic [31:0]      m_adr_q, m_adr_d;

  logic        acc, wr, busy, last;
  logic [31:0] rd;

  logic unused_ok;
  assign unused_ok = ^{s_sel_i, s_adr_i[31:4], s_adr_i[1:0]};

  assign busy = (state_q != S_IDLE);
  assign acc  = s_stb_i & s_cyc_i & ~s_ack_q;
  assign wr   = acc & s_we_i;
  assign last = (len_q == LEN_W'(1));

  always_comb begin
    rd = '0;
    unique case (s_adr_i[3:2])
      2'd0: rd = src_q;
      2'd1: rd = dst_q;
      2'd2: rd = 32'(len_q);
      2'd3: rd = {27'b0, aborted_q, ien_q,
                  done_q, busy, 1'b0};
      default: rd = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    data_d    = data_q;
    ien_d     = ien_q;
    done_d    = done_q;
    aborted_d = aborted_q;
    abort_d   = abort_q;
    s_ack_d   = acc;
    s_dat_d   = acc ? rd : '0;

    if (wr) begin
      unique case (s_adr_i[3:2])
        2'd0: if (!busy) src_d = {s_dat_i[31:2], 2'b00};
        2'd1: if (!busy) dst_d = {s_dat_i[31:2], 2'b00};
        2'd2: if (!busy) len_d = s_dat_i[LEN_W-1:0];
        2'd3: begin
          ien_d = s_dat_i[3];
          if (s_dat_i[2]) done_d = 1'b0;
          if (s_dat_i[4] && busy) abort_d = 1'b1;
          if (s_dat_i[0] && !busy) begin
            aborted_d = 1'b0;
            // zero-length copy completes without touching the bus
            if (len_q == '0) done_d = 1'b1;
            else state_d = S_READ;
          end
        end
        default: ;
      endcase
    end

    case (state_q)
      S_READ: if (m_ack_i) begin
        data_d  = m_dat_i;
        src_d   = src_q + 32'd4;
        state_d = S_WGAP;
      end
      S_WGAP: state_d = S_WRITE;
      S_WRITE: if (m_ack_i) begin
        dst_d = dst_q + 32'd4;
        len_d = len_q - LEN_W'(1);
        if (last || abort_q) begin
          state_d   = S_IDLE;
          done_d    = 1'b1;
          aborted_d = abort_q && !last;
          abort_d   = 1'b0;
        end else begin
          state_d = S_RGAP;
        end
      end
      S_RGAP: state_d = S_READ;
      default: ;
    endcase

    m_cyc_d = (state_d == S_READ) || (state_d == S_WRITE);
    m_we_d  = (state_d == S_WRITE);
    m_adr_d = (state_d == S_READ)  ? src_d :
              (state_d == S_WRITE) ? dst_d : m_adr_q;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      data_q    <= '0;
      ien_q     <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      abort_q   <= 1'b0;
      s_ack_q   <= 1'b0;
      s_dat_q   <= '0;
      m_cyc_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_adr_q   <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      data_q    <= data_d;
      ien_q     <= ien_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      abort_q   <= abort_d;
      s_ack_q   <= s_ack_d;
      s_dat_q   <= s_dat_d;
      m_cyc_q   <= m_cyc_d;
      m_we_q    <= m_we_d;
      m_adr_q   <= m_adr_d;
    end
  end

  assign s_ack_o = s_ack_q;
  assign s_dat_o = s_dat_q;
  assign m_cyc_o = m_cyc_q;
  assign m_stb_o = m_cyc_q;
  assign m_we_o  = m_we_q;
  assign m_adr_o = m_adr_q;
  assign m_dat_o = m_we_q ? data_q : '0;
  assign m_sel_o = m_cyc_q ? 4'hF : 4'h0;
  assign irq_o   = done_q & ien_q;

endmodule

// File: tb/tb_wb_dma_copy.sv
// Bench for wb_dma_copy: register programming over the slave port, a
// 1-wait-state memory responder and a queue of expected master accesses.
module tb_wb_dma_copy;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] s_adr_i = '0;
  logic [31:0] s_dat_i = '0;
  logic [31:0] s_dat_o;
  logic [3:0]  s_sel_i = 4'hF;
  logic        s_stb_i = 1'b0;
  logic        s_cyc_i = 1'b0;
  logic        s_we_i = 1'b0;
  logic        s_ack_o;
  logic [31:0] m_adr_o;
  logic [31:0] m_dat_o;
  logic [31:0] m_dat_i = '0;
  logic [3:0]  m_sel_o;
  logic        m_stb_o;
  logic        m_cyc_o;
  logic        m_we_o;
  logic        m_ack_i = 1'b0;
  logic        irq_o;

  wb_dma_copy #(.LEN_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_adr_i(s_adr_i), .s_dat_i(s_dat_i), .s_dat_o(s_dat_o),
    .s_sel_i(s_sel_i), .s_stb_i(s_stb_i), .s_cyc_i(s_cyc_i),
    .s_we_i(s_we_i), .s_ack_o(s_ack_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i),
    .m_sel_o(m_sel_o), .m_stb_o(m_stb_o), .m_cyc_o(m_cyc_o),
    .m_we_o(m_we_o), .m_ack_i(m_ack_i), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } acc_t;

  acc_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   read_cnt = 0;
  int   cyc_cycles = 0;
  int   gap = 0;
  int   wcnt = 0;
  bit   first_acc = 1'b1;
  bit   resp_en = 1'b1;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // memory responder: ack on the second cycle of every master strobe
  initial forever begin
    acc_t e;
    @(negedge clk_i);
    if (m_cyc_o) cyc_cycles++;
    if (!resp_en) begin
      wcnt = 0;
    end else if (m_ack_i) begin
      m_ack_i = 1'b0;
      wcnt = 0;
    end else if (m_cyc_o && m_stb_o) begin
      if (wcnt == 0) begin
        if (!m_we_o) read_cnt++;
        if (!first_acc) begin
          checks++;
          if (gap !== 1) begin
            errors++;
            $display("FAIL gap: got %0d idle cycles, need 1", gap);
          end
        end
        first_acc = 1'b0;
        gap = 0;
      end
      wcnt++;
      if (wcnt == 2) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_access: we=%0b adr=%h",
                   m_we_o, m_adr_o);
        end else begin
          e = exp_q.pop_front();
          if (m_we_o !== e.we || m_adr_o !== e.adr ||
              m_sel_o !== 4'hF ||
              (e.we && m_dat_o !== e.dat)) begin
            errors++;
            $display("FAIL access: got we=%0b adr=%h dat=%h, need we=%0b adr=%h dat=%h",
                     m_we_o, m_adr_o, m_dat_o, e.we, e.adr, e.dat);
          end
        end
        if (!m_we_o) m_dat_i = mem_rd(m_adr_o);
        m_ack_i = 1'b1;
      end
    end
    if (!m_cyc_o) gap++;
  end

  task automatic wb_write(input logic [1:0] idx, input logic [31:0] d);
    int n;
    @(negedge clk_i);
    s_adr_i = {28'b0, idx, 2'b00};
    s_dat_i = d;
    s_we_i  = 1'b1;
    s_stb_i = 1'b1;
    s_cyc_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!s_ack_o && n < 10);
    if (!s_ack_o) begin
      errors++;
      checks++;
      $display("FAIL slave_write_ack: got 0, need 1");
    end
    s_stb_i = 1'b0;
    s_cyc_i = 1'b0;
    s_we_i  = 1'b0;
  endtask

  task automatic wb_read(input logic [1:0] idx, output logic [31:0] d);
    int n;
    @(negedge clk_i);
    s_adr_i = {28'b0, idx, 2'b00};
    s_we_i  = 1'b0;
    s_stb_i = 1'b1;
    s_cyc_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!s_ack_o && n < 10);
    d = s_dat_o;
    if (!s_ack_o) begin
      errors++;
      checks++;
      $display("FAIL slave_read_ack: got 0, need 1");
    end
    s_stb_i = 1'b0;
    s_cyc_i = 1'b0;
  endtask

  task automatic check_reg(input string nm, input logic [1:0] idx,
                           input logic [31:0] want);
    logic [31:0] v;
    wb_read(idx, v);
    checks++;
    if (v !== want) begin
      errors++;
      $display("FAIL %s: got %h, need %h", nm, v, want);
    end
  endtask

  task automatic push_pairs(input logic [31:0] src, input logic [31:0] dst,
                            input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{1'b0, src + 32'(4 * i), 32'h0});
      exp_q.push_back('{1'b1, dst + 32'(4 * i), mem_rd(src + 32'(4 * i))});
    end
  endtask

  task automatic program_copy(input logic [31:0] src, input logic [31:0] dst,
                              input logic [31:0] len, input logic [31:0] ctrl);
    wb_write(2'd0, src);
    wb_write(2'd1, dst);
    wb_write(2'd2, len);
    first_acc = 1'b1;
    read_cnt = 0;
    wb_write(2'd3, ctrl);
  endtask

  task automatic wait_idle();
    logic [31:0] v;
    int n;
    n = 0;
    do begin
      wb_read(2'd3, v);
      n++;
    end while (v[1] && n < 300);
    checks++;
    if (v[1]) begin
      errors++;
      $display("FAIL idle_timeout: BUSY still 1 after %0d polls", n);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_access: %0d left, need 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({m_cyc_o, m_stb_o, m_we_o, s_ack_o, irq_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, need 00000",
               {m_cyc_o, m_stb_o, m_we_o, s_ack_o, irq_o});
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    check_reg("reset_src", 2'd0, 32'h0);
    check_reg("reset_ctrl", 2'd3, 32'h0);
  endtask

  task automatic test_copy4();
    push_pairs(32'h100, 32'h200, 4);
    program_copy(32'h100, 32'h200, 32'd4, 32'h1);
    wait_idle();
    check_reg("copy_ctrl", 2'd3, 32'h4);
    check_reg("copy_len", 2'd2, 32'h0);
    check_reg("copy_src", 2'd0, 32'h110);
    check_reg("copy_dst", 2'd1, 32'h210);
    wb_write(2'd3, 32'h4);
    check_reg("copy_done_clr", 2'd3, 32'h0);
  endtask

  task automatic test_len_zero();
    cyc_cycles = 0;
    program_copy(32'h400, 32'h500, 32'd0, 32'h9);
    checks++;
    if (irq_o !== 1'b1) begin
      errors++;
      $display("FAIL zero_irq: got %b, need 1", irq_o);
    end
    check_reg("zero_ctrl", 2'd3, 32'hC);
    repeat (5) @(negedge clk_i);
    checks++;
    if (cyc_cycles !== 0) begin
      errors++;
      $display("FAIL zero_no_bus: got %0d cyc cycles, need 0", cyc_cycles);
    end
    wb_write(2'd3, 32'h4);
    #1;
    checks++;
    if (irq_o !== 1'b0) begin
      errors++;
      $display("FAIL zero_irq_clr: got %b, need 0", irq_o);
    end
    check_reg("zero_ctrl_clr", 2'd3, 32'h0);
  endtask

  task automatic test_abort();
    int n;
    push_pairs(32'h1000, 32'h2000, 3);
    program_copy(32'h1000, 32'h2000, 32'd8, 32'h1);
    n = 0;
    while (!(read_cnt >= 3 && m_stb_o && !m_we_o) && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL abort_wait: 3rd read not seen");
    end
    wb_write(2'd3, 32'h10);
    wait_idle();
    check_reg("abort_len", 2'd2, 32'd5);
    check_reg("abort_ctrl", 2'd3, 32'h14);
  endtask

  task automatic test_busy_ignore();
    int n;
    push_pairs(32'h3000, 32'h4000, 3);
    program_copy(32'h3000, 32'h4000, 32'd3, 32'h5);
    n = 0;
    while (read_cnt < 1 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    wb_write(2'd0, 32'hDEAD_0000);
    wb_write(2'd3, 32'h1);
    wait_idle();
    check_reg("busy_src", 2'd0, 32'h300C);
    check_reg("busy_ctrl", 2'd3, 32'h4);
  endtask

  task automatic test_wrap();
    exp_q.push_back('{1'b0, 32'hFFFF_FFFC, 32'h0});
    exp_q.push_back('{1'b1, 32'h300, mem_rd(32'hFFFF_FFFC)});
    exp_q.push_back('{1'b0, 32'h0, 32'h0});
    exp_q.push_back('{1'b1, 32'h304, mem_rd(32'h0)});
    program_copy(32'hFFFF_FFFC, 32'h300, 32'd2, 32'h5);
    wait_idle();
    check_reg("wrap_src", 2'd0, 32'h4);
    wb_write(2'd0, 32'h103);
    check_reg("align_src", 2'd0, 32'h100);
  endtask

  task automatic test_reset_mid();
    int n;
    push_pairs(32'h800, 32'h900, 4);
    program_copy(32'h800, 32'h900, 32'd4, 32'h5);
    n = 0;
    while (!(m_we_o && m_stb_o) && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    #2;
    rst_i = 1'b0;
    #1;
    checks++;
    if ({m_cyc_o, m_stb_o, irq_o} !== 3'b0) begin
      errors++;
      $display("FAIL async_reset: got cyc/stb/irq=%b, need 000",
               {m_cyc_o, m_stb_o, irq_o});
    end
    resp_en = 1'b0;
    m_ack_i = 1'b0;
    exp_q.delete();
    @(negedge clk_i);
    rst_i = 1'b1;
    resp_en = 1'b1;
    check_reg("rst_src", 2'd0, 32'h0);
    check_reg("rst_dst", 2'd1, 32'h0);
    check_reg("rst_len", 2'd2, 32'h0);
    check_reg("rst_ctrl", 2'd3, 32'h0);
    checks++;
    if (m_cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle: got m_cyc_o=%b, need 0", m_cyc_o);
    end
  endtask

  initial begin
    test_reset();
    test_copy4();
    test_len_zero();
    test_abort();
    test_busy_ignore();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
